top: RTL and testbench
======================

TOP -- requirements
Module: top

Interface
- REQ-001 Parameter DEBOUNCE_CNT, default 500000: consecutive stable cycles needed to accept a button level (10 ms at 50 MHz); minimum 1.
- REQ-002 Parameter BLINK_DIV, default 12500000: clock cycles per blink-phase toggle (0.25 s at 50 MHz); minimum 2.
- REQ-003 clk  input  1  single system clock; all logic on its rising edge.
- REQ-004 rst_n  input  1  reset, synchronous, active-low.
- REQ-005 btn  input  3  raw asynchronous push buttons, active-high (1 = pressed).
- REQ-006 led  output  2  LED drive, active-high, registered.

Function
- REQ-007 Each btn bit SHALL pass through a 2-flop synchronizer before any other use.
- REQ-008 Each synchronized bit SHALL have its own debouncer holding a stable level and a counter.
- REQ-009 Debouncer: counter clears whenever the synchronized level equals the stable level; otherwise it increments, and on reaching DEBOUNCE_CNT the stable level takes the new value and the counter clears.
- REQ-010 A one-cycle press pulse SHALL be generated on each stable 0->1 transition; release (1->0) generates no pulse.
- REQ-011 A 2-bit mode register (0..3) SHALL be updated by press pulses:
  - btn[0] increments mod 4 (3->0).
  - btn[1] decrements mod 4 (0->3).
  - btn[2] forces mode 0.
- REQ-012 Simultaneous pulses:
  - btn[2] overrides both others.
  - btn[0] and btn[1] together without btn[2] leave mode unchanged.
- REQ-013 Blink divider: counter 0..BLINK_DIV-1; at BLINK_DIV-1 it wraps to 0 and toggles the 1-bit phase.
- REQ-014 Every mode change SHALL clear the divider and phase in the same cycle the mode register updates.
- REQ-015 led SHALL be registered from the current mode and phase:
  - mode 0: 00
  - mode 1: {0, phase}
  - mode 2: {phase, ~phase} (alternating)
  - mode 3: 11
- REQ-016 Latency: with a btn edge held constant, the press pulse SHALL assert exactly 2+DEBOUNCE_CNT cycles after the first clock edge sampling the new level; mode updates 1 cycle later; led 1 cycle after that.
- REQ-017 Bounce: a btn change that reverts before DEBOUNCE_CNT consecutive synchronized cycles SHALL produce no pulse and no mode change.
- REQ-018 Holding a button SHALL produce exactly one pulse, with no auto-repeat.

Reset
- REQ-019 While rst_n is sampled low, the following SHALL be cleared on the next clock edge:
  - synchronizer flops, debounce stable levels and counters
  - press pulses, mode (0), blink counter, phase
  - led (00)
- REQ-020 A button held through reset release SHALL register as a press after REQ-016 latency, since the stable level resets to 0.
- REQ-021 Reset asserted mid-blink or mid-debounce SHALL abandon all progress; no partial state survives.

Structure
- REQ-022 Package top_pkg SHALL hold the mode enumeration (MODE_OFF, MODE_BLINK, MODE_ALT, MODE_ON) and the default parameter constants.
- REQ-023 A sub-module btn_debounce (synchronizer + debouncer + rise pulse, parameter DEBOUNCE_CNT) SHALL be instantiated once per button; mode, divider and LED logic stay in top.

Verification (DEBOUNCE_CNT=4, BLINK_DIV=8, 10 ns clock)
- REQ-024 Reset, btn=000 for 10 cycles -> led=00 throughout.
- REQ-025 btn=001 held -> mode 1 after 7 cycles; led=00 one cycle later; led[0] then toggles every 8 cycles; led[1]=0; no further mode change while held.
- REQ-026 From mode 0, btn[0] high for 3 cycles then low -> mode stays 0, led=00.
- REQ-027 From mode 0, btn=010 press -> mode 3, led=11 steady; then btn=001 press -> mode 0, led=00.
- REQ-028 From mode 2, btn=111 in the same cycle -> mode 0, led=00; release then btn=101 -> mode 0 (btn[2] wins).
- REQ-029 Mode 2 blinking, rst_n low for 1 cycle -> led=00 the next cycle and mode 0; led stays 00 afterward with btn=000.

Source files
------------

// File: rtl/top_pkg.sv
// Shared types and constants for the button-driven LED mode controller.
package top_pkg;

   localparam int unsigned NUM_BTN          = 3;
   localparam int unsigned DEBOUNCE_CNT_DEF = 500000;
   localparam int unsigned BLINK_DIV_DEF    = 12500000;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_BLINK = 2'd1,
      MODE_ALT   = 2'd2,
      MODE_ON    = 2'd3
   } mode_e;

   // LED pattern for a given mode and blink phase
   function automatic logic [1:0] led_pattern(input mode_e mode, input logic phase);
      logic [1:0] pat;
      pat = 2'b00;
      case (mode)
         MODE_OFF:   pat = 2'b00;
         MODE_BLINK: pat = {1'b0, phase};
         MODE_ALT:   pat = {phase, ~phase};
         MODE_ON:    pat = 2'b11;
         default:    pat = 2'b00;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchronizer, counter debouncer, registered rise pulse.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CNT = 4
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_btn,
   output logic o_press
);

   // Counter only ever holds 0..DEBOUNCE_CNT-1; it clears on reaching DEBOUNCE_CNT
   localparam int unsigned CNT_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;

   logic             r_sync1;
   logic             r_sync2;
   logic             r_stable;
   logic             r_stable_d;
   logic [CNT_W-1:0] r_cnt;
   logic             r_press;
   logic             w_last;

   assign w_last  = (r_cnt == CNT_W'(DEBOUNCE_CNT - 1));
   assign o_press = r_press;

   // Synchronize the raw level into the clock domain
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
      end
   end

   // Accept a new level only after DEBOUNCE_CNT consecutive differing samples
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_stable <= 1'b0;
         r_cnt    <= '0;
      end else if (r_sync2 == r_stable) begin
         r_cnt <= '0;
      end else if (w_last) begin
         r_stable <= r_sync2;
         r_cnt    <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // One-cycle pulse on a stable 0->1 transition only
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_stable_d <= 1'b0;
         r_press    <= 1'b0;
      end else begin
         r_stable_d <= r_stable;
         r_press    <= r_stable & ~r_stable_d;
      end
   end

endmodule

// File: rtl/top.sv
// Three debounced buttons select one of four LED modes; two modes blink.
module top
   import top_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CNT = DEBOUNCE_CNT_DEF,
   parameter int unsigned BLINK_DIV    = BLINK_DIV_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_BTN-1:0] btn,
   output logic [1:0]         led
);

   localparam int unsigned BLINK_W = $clog2(BLINK_DIV);

   logic [NUM_BTN-1:0] w_press;
   mode_e              r_mode;
   mode_e              w_mode_nxt;
   logic               w_mode_chg;
   logic [BLINK_W-1:0] r_blink_cnt;
   logic               r_phase;
   logic [1:0]         r_led;

   assign led = r_led;

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CNT (DEBOUNCE_CNT)
      ) u_btn_debounce (
         .i_clk   (clk),
         .i_rst_n (rst_n),
         .i_btn   (btn[g]),
         .o_press (w_press[g])
      );
   end

   // Next mode: btn[2] forces OFF, btn[0]/btn[1] step up/down, both together cancel
   always_comb begin
      w_mode_nxt = r_mode;
      if (w_press[2]) begin
         w_mode_nxt = MODE_OFF;
      end else if (w_press[0] && !w_press[1]) begin
         w_mode_nxt = mode_e'(2'(r_mode) + 2'd1);
      end else if (w_press[1] && !w_press[0]) begin
         w_mode_nxt = mode_e'(2'(r_mode) - 2'd1);
      end
      w_mode_chg = (w_mode_nxt != r_mode);
   end

   // Mode register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mode <= MODE_OFF;
      end else begin
         r_mode <= w_mode_nxt;
      end
   end

   // Blink divider; restarts from phase 0 whenever the mode changes
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_blink_cnt <= '0;
         r_phase     <= 1'b0;
      end else if (w_mode_chg) begin
         r_blink_cnt <= '0;
         r_phase     <= 1'b0;
      end else if (r_blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
         r_blink_cnt <= '0;
         r_phase     <= ~r_phase;
      end else begin
         r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
      end
   end

   // Registered LED drive from current mode and phase
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_led <= 2'b00;
      end else begin
         r_led <= led_pattern(r_mode, r_phase);
      end
   end

endmodule

// File: tb/tb_top.sv
// Self-checking bench for top: directed scenarios plus random button activity.
module tb_top;

   localparam int unsigned DB = 4;
   localparam int unsigned BD = 8;

   logic       clk;
   logic       rst_n;
   logic [2:0] btn;
   logic [1:0] led;

   int n_total;
   int n_bad;

   top #(
      .DEBOUNCE_CNT (DB),
      .BLINK_DIV    (BD)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btn),
      .led   (led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state (value after the most recently modelled edge)
   int          cyc;
   int          t_clr;
   logic [2:0]  m_s1;
   logic [2:0]  m_s2;
   logic [2:0]  m_stable;
   int          m_run [3];
   logic [2:0]  m_rise1;
   logic [2:0]  m_rise2;
   logic [1:0]  m_mode;
   logic [1:0]  m_led;

   task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [1:0] ref_led(input logic [1:0] m, input logic ph);
      case (m)
         2'd0:    return 2'b00;
         2'd1:    return {1'b0, ph};
         2'd2:    return {ph, ~ph};
         default: return 2'b11;
      endcase
   endfunction

   function automatic logic [1:0] ref_next_mode(input logic [1:0] m, input logic [2:0] p);
      if (p[2])           return 2'd0;
      if (p[0] && p[1])   return m;
      if (p[0])           return 2'((int'(m) + 1) % 4);
      if (p[1])           return 2'((int'(m) + 3) % 4);
      return m;
   endfunction

   // Phase is how many whole blink periods have elapsed since the last clear, mod 2
   function automatic logic ref_phase(input int at_cyc);
      return 1'((((at_cyc - t_clr) / int'(BD)) % 2));
   endfunction

   task automatic model_edge(input logic [2:0] b, input logic rn);
      logic [1:0] led_nxt;
      logic [1:0] mode_nxt;
      logic [2:0] rise;
      led_nxt = ref_led(m_mode, ref_phase(cyc));
      cyc++;
      if (!rn) begin
         m_s1     = '0;
         m_s2     = '0;
         m_stable = '0;
         for (int i = 0; i < 3; i++) m_run[i] = 0;
         m_rise1  = '0;
         m_rise2  = '0;
         m_mode   = 2'd0;
         m_led    = 2'b00;
         t_clr    = cyc;
      end else begin
         // a stable rise becomes a pulse one edge later and a mode update the edge after
         mode_nxt = ref_next_mode(m_mode, m_rise2);
         m_rise2  = m_rise1;
         rise     = '0;
         for (int i = 0; i < 3; i++) begin
            if (m_s2[i] != m_stable[i]) begin
               m_run[i]++;
               if (m_run[i] == int'(DB)) begin
                  rise[i]     = m_s2[i];
                  m_stable[i] = m_s2[i];
                  m_run[i]    = 0;
               end
            end else begin
               m_run[i] = 0;
            end
         end
         m_rise1 = rise;
         m_s2    = m_s1;
         m_s1    = b;
         if (mode_nxt != m_mode) begin
            m_mode = mode_nxt;
            t_clr  = cyc;
         end
         m_led = led_nxt;
      end
   endtask

   task automatic step(input logic [2:0] b, input logic rn);
      btn   = b;
      rst_n = rn;
      @(posedge clk);
      model_edge(b, rn);
      @(negedge clk);
      check_eq("led", 32'(led), 32'(m_led));
      check_eq("mode", 32'(dut.r_mode), 32'(m_mode));
   endtask

   task automatic hold(input logic [2:0] b, input int n);
      for (int i = 0; i < n; i++) step(b, 1'b1);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) step(3'b000, 1'b0);
   endtask

   task automatic press(input logic [2:0] b);
      hold(b, 12);
      hold(3'b000, 12);
   endtask

   initial begin
      n_total = 0;
      n_bad   = 0;
      cyc     = 0;
      t_clr   = 0;
      m_mode  = 2'd0;
      m_s1    = '0;
      m_s2    = '0;
      m_stable = '0;
      m_rise1 = '0;
      m_rise2 = '0;
      m_led   = '0;
      for (int i = 0; i < 3; i++) m_run[i] = 0;
      btn     = 3'b000;
      rst_n   = 1'b0;

      // reset then idle
      do_reset(3);
      hold(3'b000, 10);

      // hold btn[0]: one step to BLINK, then blink for a long while
      hold(3'b001, 40);
      hold(3'b000, 12);

      // bounce shorter than the debounce window
      do_reset(2);
      hold(3'b001, 3);
      hold(3'b000, 12);
      hold(3'b001, 1);
      hold(3'b000, 1);
      hold(3'b001, 2);
      hold(3'b000, 12);

      // decrement wraps 0->3, increment wraps 3->0
      press(3'b010);
      press(3'b001);

      // reach ALT, then simultaneous presses
      press(3'b001);
      press(3'b001);
      hold(3'b000, 20);
      press(3'b111);
      press(3'b101);
      press(3'b001);
      press(3'b011);

      // reset mid-blink in ALT
      press(3'b001);
      hold(3'b000, 10);
      do_reset(1);
      hold(3'b000, 20);

      // button held through reset release
      hold(3'b001, 5);
      do_reset(2);
      hold(3'b001, 15);
      hold(3'b000, 10);

      // random activity with occasional reset
      for (int it = 0; it < 300; it++) begin
         if ($urandom_range(0, 39) == 0) begin
            do_reset(int'($urandom_range(1, 3)));
         end else begin
            hold(3'($urandom_range(0, 7)), int'($urandom_range(1, 10)));
            hold(3'b000, int'($urandom_range(1, 8)));
         end
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
